metro_turnstile_ctrl: RTL and testbench

Parametrised next-generation turnstile controller for one metro gate lane. It validates a pass code against a configurable accepted range. It holds the door open for a configurable time and closes it early once the passage sensor fires. It counts consecutive bad codes, locks the lane out after a limit, and raises a sticky alarm on forced passage. It sits between the code reader front end and the door actuator/status panel.

---
 rtl/turnstile_pkg.sv | 21 ++
 rtl/turnstile_timer.sv | 24 ++
 rtl/metro_turnstile_ctrl.sv | 114 +++++++++++
 tb/tb_metro_turnstile_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/turnstile_pkg.sv
// Shared state encoding, default code window and counter-width helper for the
// metro turnstile lane controller.
package turnstile_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_GRANT    = 3'd2,
    S_DENIED   = 3'd3,
    S_LOCKOUT  = 3'd4
  } state_t;

  localparam int DEF_CODE_MIN = 4;
  localparam int DEF_CODE_MAX = 11;

  // Bits needed to hold values 0..n, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/turnstile_timer.sv
// Clear/enable up-counter that holds at its terminal count instead of wrapping.
module turnstile_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         done
);

  assign done = (count == term);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/metro_turnstile_ctrl.sv
// One-lane gate controller: code range check, timed door release with early
// close on passage, consecutive-reject lockout and sticky forced-passage alarm.
module metro_turnstile_ctrl
  import turnstile_pkg::*;
#(
  parameter int CODE_W         = 4,
  parameter int CODE_MIN       = DEF_CODE_MIN,
  parameter int CODE_MAX       = DEF_CODE_MAX,
  parameter int OPEN_CYCLES    = 16,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rset,
  input  logic              validate_code,
  input  logic [CODE_W-1:0] access_code,
  input  logic              pass_sensor,
  input  logic              alarm_clr,
  output logic              open_access_door,
  output logic              denied,
  output logic              locked_out,
  output logic              alarm,
  output logic [2:0]        state_out
);

  localparam int TW = cnt_w((OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES);
  localparam int FW = cnt_w(MAX_FAIL);
  localparam logic [CODE_W-1:0] MIN_C     = CODE_W'(CODE_MIN);
  localparam logic [CODE_W-1:0] MAX_C     = CODE_W'(CODE_MAX);
  localparam logic [TW-1:0]     OPEN_TERM = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0]     LOCK_TERM = TW'(LOCKOUT_CYCLES - 1);

  if (CODE_MIN < 0 || CODE_MIN > CODE_MAX || CODE_MAX >= (1 << CODE_W) ||
      OPEN_CYCLES < 1 || MAX_FAIL < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_params
    $error("metro_turnstile_ctrl: illegal parameter combination");
  end

  state_t            state;
  logic [CODE_W-1:0] code_q;
  logic [FW-1:0]     fail_cnt;
  logic [TW-1:0]     tmr_count;
  logic [TW-1:0]     tmr_term;
  logic              tmr_run;
  logic              tmr_done;
  logic              in_range;
  logic              last_fail;

  assign in_range  = (code_q >= MIN_C) && (code_q <= MAX_C);
  assign last_fail = (int'(fail_cnt) + 1 == MAX_FAIL);

  // Timer sits at zero outside the two timed states, so each entry starts from 0.
  assign tmr_run  = (state == S_GRANT) || (state == S_LOCKOUT);
  assign tmr_term = (state == S_GRANT) ? OPEN_TERM : LOCK_TERM;

  turnstile_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rset),
    .clr   (!tmr_run),
    .en    (tmr_run),
    .term  (tmr_term),
    .count (tmr_count),
    .done  (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rset) begin
      state    <= S_IDLE;
      code_q   <= '0;
      fail_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (validate_code) begin
            code_q <= access_code;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (in_range) begin
            state    <= S_GRANT;
            fail_cnt <= '0;
          end else if (last_fail) begin
            state    <= S_LOCKOUT;
            fail_cnt <= '0;
          end else begin
            state    <= S_DENIED;
            fail_cnt <= fail_cnt + FW'(1);
          end
        end
        S_GRANT:   if (pass_sensor || tmr_done) state <= S_IDLE;
        S_DENIED:  state <= S_IDLE;
        S_LOCKOUT: if (tmr_done) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Set dominates clear when both arrive together.
  always_ff @(posedge clk) begin
    if (rset) begin
      alarm <= 1'b0;
    end else if (pass_sensor && (state != S_GRANT)) begin
      alarm <= 1'b1;
    end else if (alarm_clr) begin
      alarm <= 1'b0;
    end
  end

  assign open_access_door = (state == S_GRANT);
  assign denied           = (state == S_DENIED);
  assign locked_out       = (state == S_LOCKOUT);
  assign state_out        = state;

endmodule

// File: tb/tb_metro_turnstile_ctrl.sv
// Directed bench for metro_turnstile_ctrl with default parameters.
module tb_metro_turnstile_ctrl;

  logic       clk = 1'b0;
  logic       rset = 1'b1;
  logic       validate_code = 1'b0;
  logic [3:0] access_code = '0;
  logic       pass_sensor = 1'b0;
  logic       alarm_clr = 1'b0;
  logic       open_access_door;
  logic       denied;
  logic       locked_out;
  logic       alarm;
  logic [2:0] state_out;

  int n_cmp = 0;
  int n_bad = 0;

  metro_turnstile_ctrl dut (
    .clk              (clk),
    .rset             (rset),
    .validate_code    (validate_code),
    .access_code      (access_code),
    .pass_sensor      (pass_sensor),
    .alarm_clr        (alarm_clr),
    .open_access_door (open_access_door),
    .denied           (denied),
    .locked_out       (locked_out),
    .alarm            (alarm),
    .state_out        (state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rset = 1'b1;
    tick();
    tick();
    rset = 1'b0;
  endtask

  // Present a code for one edge; returns in the first outcome cycle.
  task automatic submit(input logic [3:0] code);
    validate_code = 1'b1;
    access_code   = code;
    tick();
    validate_code = 1'b0;
    chk("check_state", state_out, 1);
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (state_out != 3'd0 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, state_out, 0);
  endtask

  initial begin
    int n;
    logic [3:0] bcode [4] = '{4'd3, 4'd4, 4'd11, 4'd12};
    int         bgrant[4] = '{0, 1, 1, 0};

    do_reset();
    chk("rst_state", state_out, 0);
    chk("rst_door", open_access_door, 0);
    chk("rst_denied", denied, 0);
    chk("rst_locked", locked_out, 0);
    chk("rst_alarm", alarm, 0);

    // Valid code, full-length open window
    submit(4'd7);
    chk("grant_state", state_out, 2);
    n = 0;
    while (open_access_door && n < 100) begin
      n++;
      tick();
    end
    chk("grant_len", n, 16);
    chk("grant_end_state", state_out, 0);

    // Early close on passage in third open cycle
    submit(4'd4);
    chk("early_door1", open_access_door, 1);
    tick();
    tick();
    chk("early_door3", open_access_door, 1);
    pass_sensor = 1'b1;
    tick();
    pass_sensor = 1'b0;
    chk("early_door_off", open_access_door, 0);
    chk("early_state", state_out, 0);
    chk("early_alarm", alarm, 0);

    // Range boundaries
    for (int i = 0; i < 4; i++) begin
      do_reset();
      submit(bcode[i]);
      chk($sformatf("bnd%0d_door", bcode[i]), open_access_door, bgrant[i]);
      chk($sformatf("bnd%0d_denied", bcode[i]), denied, 1 - bgrant[i]);
      wait_idle($sformatf("bnd%0d_idle", bcode[i]));
      tick();
    end

    // Denied pulse width and lockout
    do_reset();
    submit(4'd0);
    chk("lk_den1", denied, 1);
    tick();
    chk("lk_den1_off", denied, 0);
    chk("lk_den1_idle", state_out, 0);
    submit(4'd0);
    chk("lk_den2", denied, 1);
    tick();
    submit(4'd0);
    chk("lk_state", state_out, 4);
    chk("lk_denied", denied, 0);
    n = 0;
    while (locked_out && n < 100) begin
      validate_code = (n == 5);
      access_code   = 4'd5;
      n++;
      tick();
    end
    validate_code = 1'b0;
    chk("lk_len", n, 32);
    chk("lk_end_state", state_out, 0);
    submit(4'd5);
    chk("lk_after_grant", open_access_door, 1);
    wait_idle("lk_after_idle");

    // Grant clears the reject count
    do_reset();
    submit(4'd0);
    chk("fr_den1", denied, 1);
    tick();
    submit(4'd0);
    chk("fr_den2", denied, 1);
    tick();
    submit(4'd9);
    chk("fr_grant", open_access_door, 1);
    wait_idle("fr_idle");
    submit(4'd0);
    chk("fr_den3", state_out, 3);
    tick();

    // Alarm set/clear priority and mid-grant reset
    do_reset();
    pass_sensor = 1'b1;
    tick();
    pass_sensor = 1'b0;
    chk("al_set", alarm, 1);
    chk("al_state", state_out, 0);
    pass_sensor = 1'b1;
    alarm_clr   = 1'b1;
    tick();
    pass_sensor = 1'b0;
    alarm_clr   = 1'b0;
    chk("al_set_wins", alarm, 1);
    alarm_clr = 1'b1;
    tick();
    alarm_clr = 1'b0;
    chk("al_clr", alarm, 0);
    submit(4'd6);
    tick();
    tick();
    chk("mid_door", open_access_door, 1);
    rset = 1'b1;
    tick();
    chk("mid_rst_door", open_access_door, 0);
    chk("mid_rst_state", state_out, 0);
    rset = 1'b0;
    tick();
    chk("mid_rst_hold", state_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
